// File: rtl/egress_shaper.sv
// -----------------------------------------------------------------------------
// egress_shaper
//
// Per-port egress stage placed directly downstream of one switch output port.
// Packets are buffered in a small circular FIFO and released to the link under
// a token-bucket rate limit. Occupancy and simple statistics are exported for
// telemetry.
//
// Parameters
//   PKT_WIDTH  packet word width (matches the switch packet width)
//   DEPTH      FIFO entries, power of two, >= 2
//   TOKEN_W    width of the token bucket and of every cfg_* field
//
// Ports
//   clk           single clock, rising edge
//   rst_n         synchronous active-low reset
//   s_pkt/s_valid/s_ready   packet input from the switch (valid/ready)
//   m_pkt/m_valid/m_ready   packet output to the link (valid/ready)
//   cfg_en        1 = shaping enabled, 0 = token check bypassed
//   cfg_rate      tokens added per cycle
//   cfg_burst     bucket ceiling
//   cfg_cost      tokens debited per packet sent
//   occupancy     registered FIFO entry count
//   tx_count      packets sent, wraps modulo 2^32
//   stall_cycles  cycles spent waiting for tokens, saturating
// -----------------------------------------------------------------------------
module egress_shaper #(
    parameter int PKT_WIDTH = 64,
    parameter int DEPTH     = 8,
    parameter int TOKEN_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,

    input  logic [PKT_WIDTH-1:0]       s_pkt,
    input  logic                       s_valid,
    output logic                       s_ready,

    output logic [PKT_WIDTH-1:0]       m_pkt,
    output logic                       m_valid,
    input  logic                       m_ready,

    input  logic                       cfg_en,
    input  logic [TOKEN_W-1:0]         cfg_rate,
    input  logic [TOKEN_W-1:0]         cfg_burst,
    input  logic [TOKEN_W-1:0]         cfg_cost,

    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [31:0]                tx_count,
    output logic [31:0]                stall_cycles
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_TOK,
        ST_SEND
    } state_t;

    // -------------------------------------------------------------------------
    // Arithmetic helpers
    // -------------------------------------------------------------------------

    // Bucket update: add the refill, remove the debit (never below zero) and
    // clamp to the ceiling. Done one bit wider so the add cannot wrap.
    function automatic logic [TOKEN_W-1:0] bucket_next(
        input logic [TOKEN_W-1:0] cur,
        input logic [TOKEN_W-1:0] rate,
        input logic [TOKEN_W-1:0] debit,
        input logic [TOKEN_W-1:0] ceil_v
    );
        logic [TOKEN_W:0] sum;
        logic [TOKEN_W:0] net;
        sum = {1'b0, cur} + {1'b0, rate};
        if (sum < {1'b0, debit}) begin
            net = '0;
        end else begin
            net = sum - {1'b0, debit};
        end
        if (net > {1'b0, ceil_v}) begin
            return ceil_v;
        end
        return net[TOKEN_W-1:0];
    endfunction

    // Saturating 32-bit increment for the stall statistic.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        if (v == 32'hFFFF_FFFF) begin
            return v;
        end
        return v + 32'd1;
    endfunction

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    logic [PKT_WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [TOKEN_W-1:0] tokens_q, tokens_d;
    state_t             state_q, state_d;
    logic               m_valid_q, m_valid_d;
    logic [31:0]        tx_count_q, tx_count_d;
    logic [31:0]        stall_q, stall_d;

    logic               push;
    logic               pop;
    logic [TOKEN_W-1:0] debit;
    logic               elig_now;
    logic               elig_post;

    // -------------------------------------------------------------------------
    // Handshakes and FIFO bookkeeping
    // -------------------------------------------------------------------------

    // s_ready depends only on the registered count, so a full FIFO refuses a
    // push even when the head is popped in the same cycle.
    assign s_ready = (count_q != FULL_CNT);
    assign push    = s_valid && s_ready;
    assign pop     = m_valid_q && m_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // -------------------------------------------------------------------------
    // Token bucket
    // -------------------------------------------------------------------------

    // The bucket keeps refilling while shaping is disabled so that enabling
    // it later starts from a realistic credit level.
    always_comb begin
        debit    = pop ? cfg_cost : '0;
        tokens_d = bucket_next(tokens_q, cfg_rate, debit, cfg_burst);
    end

    assign elig_now  = !cfg_en || (tokens_q >= cfg_cost);
    // After a pop the decision uses the post-debit balance so back-to-back
    // sends are only granted when the next packet is already paid for.
    assign elig_post = !cfg_en || (tokens_d >= cfg_cost);

    // -------------------------------------------------------------------------
    // Release FSM
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    state_d = elig_now ? ST_SEND : ST_WAIT_TOK;
                end
            end
            ST_WAIT_TOK: begin
                if (elig_now) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                // Without a pop the packet is held; cfg changes cannot pull
                // back a packet that has already been offered.
                if (pop) begin
                    if (count_d == '0) begin
                        state_d = ST_IDLE;
                    end else if (elig_post) begin
                        state_d = ST_SEND;
                    end else begin
                        state_d = ST_WAIT_TOK;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        m_valid_d = (state_d == ST_SEND);
    end

    // -------------------------------------------------------------------------
    // Statistics
    // -------------------------------------------------------------------------
    always_comb begin
        tx_count_d = pop ? (tx_count_q + 32'd1) : tx_count_q;
        stall_d    = (state_q == ST_WAIT_TOK) ? sat_inc32(stall_q) : stall_q;
    end

    // -------------------------------------------------------------------------
    // Sequential elements
    // -------------------------------------------------------------------------

    // Packet storage carries no reset; entries are only read once written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_pkt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tokens_q   <= '0;
            state_q    <= ST_IDLE;
            m_valid_q  <= 1'b0;
            tx_count_q <= '0;
            stall_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tokens_q   <= tokens_d;
            state_q    <= state_d;
            m_valid_q  <= m_valid_d;
            tx_count_q <= tx_count_d;
            stall_q    <= stall_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------

    // The head entry cannot be overwritten while it is offered: a push into
    // the head slot requires an empty or full FIFO, neither of which applies.
    assign m_pkt        = mem_q[rd_ptr_q];
    assign m_valid      = m_valid_q;
    assign occupancy    = count_q;
    assign tx_count     = tx_count_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_egress_shaper.sv
module tb_egress_shaper;

    localparam int PKT_WIDTH = 64;
    localparam int DEPTH     = 8;
    localparam int TOKEN_W   = 16;

    logic                   clk;
    logic                   rst_n;
    logic [PKT_WIDTH-1:0]   s_pkt;
    logic                   s_valid;
    logic                   s_ready;
    logic [PKT_WIDTH-1:0]   m_pkt;
    logic                   m_valid;
    logic                   m_ready;
    logic                   cfg_en;
    logic [TOKEN_W-1:0]     cfg_rate;
    logic [TOKEN_W-1:0]     cfg_burst;
    logic [TOKEN_W-1:0]     cfg_cost;
    logic [$clog2(DEPTH):0] occupancy;
    logic [31:0]            tx_count;
    logic [31:0]            stall_cycles;

    egress_shaper #(
        .PKT_WIDTH (PKT_WIDTH),
        .DEPTH     (DEPTH),
        .TOKEN_W   (TOKEN_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_pkt        (s_pkt),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .m_pkt        (m_pkt),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .cfg_en       (cfg_en),
        .cfg_rate     (cfg_rate),
        .cfg_burst    (cfg_burst),
        .cfg_cost     (cfg_cost),
        .occupancy    (occupancy),
        .tx_count     (tx_count),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;

    logic [PKT_WIDTH-1:0] got [32];
    int                   pop_at [32];
    int                   npop;
    int                   first_mv;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_pkt   = '0;
        step();
        step();
        rst_n = 1'b1;
        npop     = 0;
        first_mv = 0;
    endtask

    // Record a transfer that will happen at the coming edge.
    task automatic note_pop(input int k);
        if (m_valid && m_ready && npop < 32) begin
            got[npop]    = m_pkt;
            pop_at[npop] = k;
            npop++;
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        s_valid = 1'b1;
        s_pkt   = 64'hDEAD;
        m_ready = 1'b0;
        repeat (3) step();
        rst_n   = 1'b1;
        s_valid = 1'b0;
        n_cmp++;
        if (m_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_m_valid: got %0b, expected 0", m_valid);
        end
        n_cmp++;
        if (occupancy !== 4'd0) begin
            n_err++; $display("FAIL reset_occupancy: got %0d, expected 0", occupancy);
        end
        n_cmp++;
        if (tx_count !== 32'd0) begin
            n_err++; $display("FAIL reset_tx_count: got %0d, expected 0", tx_count);
        end
        n_cmp++;
        if (stall_cycles !== 32'd0) begin
            n_err++; $display("FAIL reset_stall: got %0d, expected 0", stall_cycles);
        end
        n_cmp++;
        if (s_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_s_ready: got %0b, expected 1", s_ready);
        end
    endtask

    task automatic test_bypass();
        cfg_en = 1'b0; cfg_rate = 16'd0; cfg_burst = 16'd8; cfg_cost = 16'd4;
        m_ready = 1'b1;
        do_reset();
        for (int k = 1; k <= 14; k++) begin
            s_valid = (k <= 8);
            s_pkt   = 64'(k);
            note_pop(k);
            step();
            if (m_valid && first_mv == 0) first_mv = k;
        end
        s_valid = 1'b0;
        n_cmp++;
        if (first_mv !== 2) begin
            n_err++; $display("FAIL bypass_latency: got edge %0d, expected 2", first_mv);
        end
        n_cmp++;
        if (npop !== 8) begin
            n_err++; $display("FAIL bypass_npop: got %0d, expected 8", npop);
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (got[i] !== 64'(i + 1) || pop_at[i] !== i + 3) begin
                n_err++;
                $display("FAIL bypass_order[%0d]: got pkt %0h at edge %0d, expected pkt %0h at edge %0d",
                         i, got[i], pop_at[i], i + 1, i + 3);
            end
        end
        n_cmp++;
        if (tx_count !== 32'd8) begin
            n_err++; $display("FAIL bypass_tx_count: got %0d, expected 8", tx_count);
        end
        n_cmp++;
        if (stall_cycles !== 32'd0) begin
            n_err++; $display("FAIL bypass_stall: got %0d, expected 0", stall_cycles);
        end
    endtask

    task automatic test_shaping();
        cfg_en = 1'b1; cfg_rate = 16'd1; cfg_burst = 16'd8; cfg_cost = 16'd4;
        m_ready = 1'b1;
        do_reset();
        for (int k = 1; k <= 40; k++) begin
            s_valid = (k <= 6);
            s_pkt   = 64'(k);
            note_pop(k);
            step();
            if (m_valid && first_mv == 0) first_mv = k;
        end
        s_valid = 1'b0;
        // tokens reach 4 after edge 4, so SEND is entered at edge 5
        n_cmp++;
        if (first_mv !== 5) begin
            n_err++; $display("FAIL shape_first: got edge %0d, expected 5", first_mv);
        end
        n_cmp++;
        if (npop !== 6) begin
            n_err++; $display("FAIL shape_npop: got %0d, expected 6", npop);
        end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (got[i] !== 64'(i + 1) || pop_at[i] !== 6 + 4 * i) begin
                n_err++;
                $display("FAIL shape_spacing[%0d]: got pkt %0h at edge %0d, expected pkt %0h at edge %0d",
                         i, got[i], pop_at[i], i + 1, 6 + 4 * i);
            end
        end
        // 3 waiting cycles before the first send plus 3 in each of 5 gaps
        n_cmp++;
        if (stall_cycles !== 32'd18) begin
            n_err++; $display("FAIL shape_stall: got %0d, expected 18", stall_cycles);
        end
        n_cmp++;
        if (tx_count !== 32'd6) begin
            n_err++; $display("FAIL shape_tx_count: got %0d, expected 6", tx_count);
        end
    endtask

    task automatic test_full_backpressure();
        int  nacc;
        logic acc;
        cfg_en = 1'b0; cfg_rate = 16'd0; cfg_burst = 16'd8; cfg_cost = 16'd4;
        m_ready = 1'b0;
        do_reset();
        nacc = 0;
        for (int k = 1; k <= 10; k++) begin
            s_valid = 1'b1;
            s_pkt   = 64'h100 + 64'(nacc);
            acc     = s_ready;
            step();
            if (acc) nacc++;
        end
        n_cmp++;
        if (nacc !== 8) begin
            n_err++; $display("FAIL full_accepted: got %0d, expected 8", nacc);
        end
        n_cmp++;
        if (s_ready !== 1'b0) begin
            n_err++; $display("FAIL full_s_ready: got %0b, expected 0", s_ready);
        end
        n_cmp++;
        if (occupancy !== 4'd8) begin
            n_err++; $display("FAIL full_occupancy: got %0d, expected 8", occupancy);
        end
        n_cmp++;
        if (m_valid !== 1'b1 || m_pkt !== 64'h100) begin
            n_err++; $display("FAIL full_hold: got valid %0b pkt %0h, expected valid 1 pkt 100", m_valid, m_pkt);
        end
        // Full and popping in the same cycle: the push must still be refused.
        m_ready = 1'b1;
        s_pkt   = 64'h100 + 64'(nacc);
        acc     = s_ready;
        note_pop(0);
        step();
        if (acc) nacc++;
        n_cmp++;
        if (occupancy !== 4'd7 || nacc !== 8) begin
            n_err++; $display("FAIL full_pop_no_push: got occupancy %0d accepted %0d, expected 7 and 8", occupancy, nacc);
        end
        for (int k = 1; k <= 20; k++) begin
            s_valid = (nacc < 10);
            s_pkt   = 64'h100 + 64'(nacc);
            acc     = s_valid && s_ready;
            note_pop(k);
            step();
            if (acc) nacc++;
        end
        s_valid = 1'b0;
        n_cmp++;
        if (npop !== 10 || nacc !== 10) begin
            n_err++; $display("FAIL full_drain_count: got pops %0d accepted %0d, expected 10 and 10", npop, nacc);
        end
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (got[i] !== 64'h100 + 64'(i)) begin
                n_err++; $display("FAIL full_drain_order[%0d]: got %0h, expected %0h", i, got[i], 64'h100 + 64'(i));
            end
        end
        n_cmp++;
        if (occupancy !== 4'd0 || tx_count !== 32'd10) begin
            n_err++; $display("FAIL full_end: got occupancy %0d tx %0d, expected 0 and 10", occupancy, tx_count);
        end
    endtask

    task automatic test_burst_cap();
        int waited;
        cfg_en = 1'b1; cfg_rate = 16'd5; cfg_burst = 16'd8; cfg_cost = 16'd4;
        m_ready = 1'b1;
        do_reset();
        repeat (20) step();
        // Stop refilling so only the saturated credit of 8 is available.
        cfg_rate = 16'd0;
        for (int k = 1; k <= 8; k++) begin
            s_valid = (k <= 3);
            s_pkt   = 64'h200 + 64'(k);
            note_pop(k);
            step();
        end
        s_valid = 1'b0;
        n_cmp++;
        if (npop !== 2) begin
            n_err++; $display("FAIL burst_npop: got %0d, expected 2", npop);
        end
        n_cmp++;
        if (got[0] !== 64'h201 || pop_at[0] !== 3 || got[1] !== 64'h202 || pop_at[1] !== 4) begin
            n_err++;
            $display("FAIL burst_b2b: got %0h@%0d %0h@%0d, expected 201@3 202@4", got[0], pop_at[0], got[1], pop_at[1]);
        end
        n_cmp++;
        if (m_valid !== 1'b0 || occupancy !== 4'd1) begin
            n_err++; $display("FAIL burst_wait: got valid %0b occupancy %0d, expected 0 and 1", m_valid, occupancy);
        end
        n_cmp++;
        if (stall_cycles !== 32'd4) begin
            n_err++; $display("FAIL burst_stall: got %0d, expected 4", stall_cycles);
        end
        // Refill, then raise the cost while the packet is offered.
        m_ready  = 1'b0;
        cfg_rate = 16'd5;
        waited   = 0;
        while (!m_valid && waited < 10) begin
            step();
            waited++;
        end
        n_cmp++;
        if (m_valid !== 1'b1) begin
            n_err++; $display("FAIL burst_refill_timeout: got valid %0b after %0d cycles, expected 1", m_valid, waited);
        end
        cfg_cost = 16'hFFFF;
        repeat (3) step();
        n_cmp++;
        if (m_valid !== 1'b1 || m_pkt !== 64'h203) begin
            n_err++; $display("FAIL cfg_change_hold: got valid %0b pkt %0h, expected valid 1 pkt 203", m_valid, m_pkt);
        end
        m_ready = 1'b1;
        step();
        n_cmp++;
        if (m_valid !== 1'b0 || occupancy !== 4'd0 || tx_count !== 32'd3) begin
            n_err++;
            $display("FAIL cfg_change_pop: got valid %0b occupancy %0d tx %0d, expected 0 0 3", m_valid, occupancy, tx_count);
        end
        cfg_cost = 16'd4;
    endtask

    task automatic test_reset_midstream();
        cfg_en = 1'b0; cfg_rate = 16'd0; cfg_burst = 16'd8; cfg_cost = 16'd4;
        m_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            s_valid = 1'b1;
            s_pkt   = 64'h300 + 64'(k);
            step();
        end
        s_valid = 1'b0;
        step();
        n_cmp++;
        if (m_valid !== 1'b1 || occupancy !== 4'd5) begin
            n_err++; $display("FAIL mid_pre: got valid %0b occupancy %0d, expected 1 and 5", m_valid, occupancy);
        end
        rst_n = 1'b0;
        step();
        n_cmp++;
        if (m_valid !== 1'b0 || occupancy !== 4'd0 || s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reset: got valid %0b occupancy %0d s_ready %0b, expected 0 0 1", m_valid, occupancy, s_ready);
        end
        rst_n   = 1'b1;
        m_ready = 1'b1;
        npop    = 0;
        for (int k = 1; k <= 8; k++) begin
            s_valid = (k <= 2);
            s_pkt   = 64'h400 + 64'(k - 1);
            note_pop(k);
            step();
        end
        s_valid = 1'b0;
        n_cmp++;
        if (npop !== 2 || got[0] !== 64'h400 || got[1] !== 64'h401) begin
            n_err++;
            $display("FAIL mid_fresh: got %0d pops first %0h second %0h, expected 2 pops 400 401", npop, got[0], got[1]);
        end
        n_cmp++;
        if (tx_count !== 32'd2) begin
            n_err++; $display("FAIL mid_tx_count: got %0d, expected 2", tx_count);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        npop      = 0;
        first_mv  = 0;
        rst_n     = 1'b0;
        s_valid   = 1'b0;
        s_pkt     = '0;
        m_ready   = 1'b0;
        cfg_en    = 1'b0;
        cfg_rate  = '0;
        cfg_burst = 16'd8;
        cfg_cost  = 16'd4;

        test_reset();
        test_bypass();
        test_shaping();
        test_full_backpressure();
        test_burst_cap();
        test_reset_midstream();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/egress_shaper.md
# egress_shaper

Per-port egress stage that sits directly downstream of one `ai_switch` output port (`out_pkt`/`out_valid`/`out_ready`). It buffers packets in a small FIFO and releases them to the link under a token-bucket rate limit. It also exposes occupancy and statistics for telemetry. One instance is placed per switch port.

## Interface
- `PKT_WIDTH`, 64: packet word width; matches the switch `PKT_WIDTH`.
- `DEPTH`, 8: FIFO entries; must be a power of two, at least 2.
- `TOKEN_W`, 16: width of the token bucket and all `cfg_*` fields.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `s_pkt`  in  PKT_WIDTH  packet from the switch `out_pkt[i]`.
- `s_valid`  in  1  from the switch `out_valid[i]`.
- `s_ready`  out  1  to the switch `out_ready[i]`.
- `m_pkt`  out  PKT_WIDTH  packet to the link.
- `m_valid`  out  1  link valid.
- `m_ready`  in  1  link ready.
- `cfg_en`  in  1  1 = shaping on; 0 = token check bypassed.
- `cfg_rate`  in  TOKEN_W  tokens added per cycle.
- `cfg_burst`  in  TOKEN_W  bucket ceiling.
- `cfg_cost`  in  TOKEN_W  tokens debited per packet sent.
- `occupancy`  out  $clog2(DEPTH)+1  FIFO entry count.
- `tx_count`  out  32  packets sent; wraps modulo 2^32.
- `stall_cycles`  out  32  cycles spent in WAIT_TOK; saturates at 0xFFFF_FFFF.

## Operation
- **FIFO**
  - Circular buffer with write/read pointers of $clog2(DEPTH) bits; both wrap naturally.
  - `count` is $clog2(DEPTH)+1 bits.
  - `s_ready = (count != DEPTH)`, combinational from registered `count`.
  - Push when `s_valid && s_ready`. When full, a push is refused even if a pop happens in the same cycle.
  - Pop when `m_valid && m_ready`.
  - A simultaneous push and pop leaves `count` unchanged.
- **Token bucket**
  - `tokens` is TOKEN_W bits; reset value 0.
  - `debit = pop ? cfg_cost : 0`.
  - `tokens_next = min(tokens - debit + cfg_rate, cfg_burst)`, computed in TOKEN_W+1 bits. The add saturates at `cfg_burst`.
  - The bucket updates every cycle, including when `cfg_en = 0`.
  - A packet is eligible when `!cfg_en || tokens >= cfg_cost`.
- **FSM**: three states IDLE, WAIT_TOK, SEND; reset state IDLE. `m_valid = (state == SEND)`, registered.
  - IDLE: if `count == 0`, stay. Otherwise go to SEND if eligible, else WAIT_TOK.
  - WAIT_TOK: go to SEND when eligible. `stall_cycles` increments every cycle spent in WAIT_TOK.
  - SEND: hold until `m_ready`. On pop, re-evaluate using post-pop `count` and `tokens_next`:
    - count > 0 and `tokens_next >= cfg_cost` (or `!cfg_en`) → SEND;
    - count > 0 otherwise → WAIT_TOK;
    - count == 0 → IDLE.
- `m_pkt` is the FIFO head entry. While `m_valid = 1` and `m_ready = 0`, `m_pkt` and `m_valid` are held stable.
- Changing `cfg_*` while in SEND never deasserts `m_valid`; the tokens were already committed when SEND was entered.
- If `tokens < cfg_cost` at the pop, the bucket floors at 0 (no negative tokens).
- `tx_count` increments on every pop.

## Timing
- **Reset** (`rst_n = 0` at an edge):
  - Pointers, `count`, `tokens` = 0; `state` = IDLE.
  - `m_valid` = 0; `s_ready` = 1 one cycle after reset.
  - `occupancy`, `tx_count`, `stall_cycles` = 0.
  - FIFO contents are don't-care; `m_pkt` is don't-care while `m_valid = 0`.
- **Reset mid-operation**: all buffered packets are discarded, with no partial output.
- **Minimum latency**:
  - push at edge t → `count > 0` after t;
  - FSM enters SEND at edge t+1;
  - `m_valid` high in the cycle after t+1.
  - So `m_valid` rises 2 cycles after the push.
- **Throughput**: one packet per cycle when eligible and `m_ready = 1` (back-to-back SEND).
- **Rate**: steady-state spacing is `ceil(cfg_cost / cfg_rate)` cycles per packet.
- `occupancy` reflects registered `count`: updated the edge after a push/pop.

## Test plan
- **Reset**: hold `rst_n = 0` for 3 cycles with `s_valid = 1` → `m_valid = 0`, `occupancy = 0`, `tx_count = 0`, `s_ready = 1` after release.
- **Bypass**: `cfg_en = 0`, `m_ready = 1`, push 8 back-to-back packets 0x1..0x8 → first `m_valid` 2 cycles after the first push; packets 0x1..0x8 out in order on consecutive cycles; `tx_count = 8`.
- **Shaping**: `cfg_en = 1`, `rate = 1`, `cost = 4`, `burst = 8`, preload 6 packets, `m_ready = 1` → first packet at tokens ≥ 4; steady-state spacing 4 cycles; `stall_cycles` increments during gaps.
- **Full/backpressure**: `m_ready = 0`, push 10 packets → `s_ready` drops after 8 accepted; `occupancy = 8`; `m_pkt` stable. Then raise `m_ready` → all 8 drain in order, then the remaining 2 are accepted.
- **Burst cap**: `rate = 5`, `burst = 8`, idle 20 cycles → tokens saturate at 8. With `cost = 4`, exactly 2 back-to-back sends, then WAIT_TOK.
- **Reset mid-stream**: assert `rst_n = 0` with 5 packets queued and `m_valid = 1` → next cycle `m_valid = 0`, `occupancy = 0`; packets after release appear with fresh ordering.
